// File: rtl/hdsiso_bank_if.sv
// Serial-delay bank bus: stream/control inputs and observation outputs of hdsiso_bank.
interface hdsiso_bank_if #(
  parameter int unsigned JW     = 4,
  parameter int unsigned LFSR_W = 8
);
  localparam int unsigned P = 2 * JW;

  logic              EN;
  logic              D_IN;
  logic              DIN_SEL;
  logic              LFSR_EN;
  logic              D_OUT;
  logic              D_VALID;
  logic [JW-1:0]     JOHNSON;
  logic [P-1:0]      PULSES;
  logic              LFSR_BIT;
  logic              LFSR_PERIOD;
  logic [LFSR_W-1:0] LFSR_STATE;

  // Stimulus side: drives the stream and control, observes the bank.
  modport master (
    output EN, D_IN, DIN_SEL, LFSR_EN,
    input  D_OUT, D_VALID, JOHNSON, PULSES, LFSR_BIT, LFSR_PERIOD, LFSR_STATE
  );

  // Bank side.
  modport slave (
    input  EN, D_IN, DIN_SEL, LFSR_EN,
    output D_OUT, D_VALID, JOHNSON, PULSES, LFSR_BIT, LFSR_PERIOD, LFSR_STATE
  );
endinterface

// File: rtl/hdsiso_bank.sv
// Johnson-sequenced multi-lane serial delay line (P*DEPTH enabled cycles) with
// fill flag and a built-in Fibonacci LFSR as a self-test source.
module hdsiso_bank #(
  parameter int unsigned        JW     = 4,
  parameter int unsigned        DEPTH  = 4,
  parameter int unsigned        LFSR_W = 8,
  parameter logic [LFSR_W-1:0]  TAPS   = LFSR_W'(8'hB8)
) (
  input  logic         CLK,
  input  logic         RESET,
  hdsiso_bank_if.slave bus
);

  localparam int unsigned P   = 2 * JW;
  localparam int unsigned L   = P * DEPTH;
  localparam int unsigned CW  = $clog2(L + 1);
  localparam int unsigned PHW = $clog2(P + 1);

  logic [JW-1:0]               j_q, j_d;
  logic [P-1:0][DEPTH-1:0]     lane_q, lane_d;
  logic                        dout_q, dout_d;
  logic                        valid_q, valid_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [LFSR_W-1:0]           lfsr_q, lfsr_d;

  logic [PHW-1:0]              ph_c;
  logic                        j_legal_c;
  logic                        sin_c;
  logic [P-1:0]                pulses_c;

  function automatic logic [PHW-1:0] popcnt(input logic [JW-1:0] v);
    logic [PHW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < JW; i++) begin
      n = n + PHW'(v[i]);
    end
    return n;
  endfunction

  // Phase decode and legality: a Johnson code is a run of ones anchored at
  // either the low end (0..01..1) or the high end (1..10..0).
  always_comb begin
    logic [PHW-1:0] pop;
    logic [JW-1:0]  j_inc;
    logic [JW-1:0]  j_inv;
    logic [JW-1:0]  j_inv_inc;
    pop       = popcnt(j_q);
    ph_c      = j_q[JW-1] ? (PHW'(P) - pop) : pop;
    j_inc     = j_q + JW'(1);
    j_inv     = ~j_q;
    j_inv_inc = j_inv + JW'(1);
    j_legal_c = ((j_q & j_inc) == '0) || ((j_inv & j_inv_inc) == '0);
  end

  // One-hot phase strobe, suppressed while idle or in reset.
  always_comb begin
    pulses_c = '0;
    for (int unsigned k = 0; k < P; k++) begin
      pulses_c[k] = bus.EN & ~RESET & (ph_c == PHW'(k));
    end
  end

  // Serial source mux; the LFSR bit is the pre-advance value.
  always_comb begin
    sin_c = bus.DIN_SEL ? lfsr_q[LFSR_W-1] : bus.D_IN;
  end

  // Next-state: Johnson step, active-lane shift, fill count, LFSR step.
  always_comb begin
    j_d     = j_q;
    lane_d  = lane_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    lfsr_d  = lfsr_q;

    if (!j_legal_c) begin
      j_d = '0;
    end else if (bus.EN) begin
      j_d = {j_q[JW-2:0], ~j_q[JW-1]};
    end

    if (bus.EN) begin
      for (int unsigned k = 0; k < P; k++) begin
        if (ph_c == PHW'(k)) begin
          lane_d[k] = {lane_q[k][DEPTH-2:0], sin_c};
          dout_d    = lane_q[k][DEPTH-1];
        end
      end
      if (cnt_q != CW'(L)) begin
        cnt_d = cnt_q + CW'(1);
      end
      valid_d = valid_q | (cnt_d == CW'(L));
    end

    if (lfsr_q == '0) begin
      lfsr_d = LFSR_W'(1);
    end else if (bus.LFSR_EN) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      j_q     <= '0;
      lane_q  <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_W'(1);
    end else begin
      j_q     <= j_d;
      lane_q  <= lane_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign bus.D_OUT       = dout_q;
  assign bus.D_VALID     = valid_q;
  assign bus.JOHNSON     = j_q;
  assign bus.PULSES      = pulses_c;
  assign bus.LFSR_BIT    = lfsr_q[LFSR_W-1];
  assign bus.LFSR_PERIOD = (lfsr_q == LFSR_W'(1));
  assign bus.LFSR_STATE  = lfsr_q;

endmodule
